// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, bit-period derivation and rx FSM states.
package uart_pkg;

    localparam int DEF_CLOCK_FREQ = 50_000_000;
    localparam int DEF_BAUD_RATE  = 9600;
    localparam int DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic int calc_ticks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and valid/ack byte handoff.
// Define UART_RX_MAJORITY_EN to replace single sampling with a 2-of-3 vote.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ    = DEF_CLOCK_FREQ,
    parameter int BAUD_RATE     = DEF_BAUD_RATE,
    parameter int TICKS_PER_BIT = calc_ticks(CLOCK_FREQ, BAUD_RATE),
    parameter int HALF_TICKS    = TICKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] FULL_LAST = 16'(TICKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_TICKS - 1);

    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_rx_s;
    logic        w_sample;
    logic [15:0] w_last;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    assign w_last = (r_state == START) ? HALF_LAST : FULL_LAST;

`ifdef UART_RX_MAJORITY_EN
    // Votes captured two and one cycles before the decision point; the third is live rx_s.
    logic r_v0;
    logic r_v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else begin
            if (r_cnt == w_last - 16'd2) r_v0 <= w_rx_s;
            if (r_cnt == w_last - 16'd1) r_v1 <= w_rx_s;
        end
    end

    assign w_sample = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Ack is applied first so a same-cycle delivery below wins.
            if (rx_ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= 16'd0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                        r_state <= w_sample ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {w_sample, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= 16'd0;
                        if (w_sample) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            if (r_valid && !rx_ack) r_overrun <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-scenario observation record, indexed by drive cycle (d=0 is the start bit's first cycle).
    int cur_d, v_it, ferr_it, ferr_cnt, bh_it, bl_it;
    logic prev_valid, prev_busy;

    uart_receiver #(
        .CLOCK_FREQ (160000),
        .BAUD_RATE  (10000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clr_mon();
        cur_d = -1; v_it = -1; ferr_it = -1; ferr_cnt = 0; bh_it = -1; bl_it = -1;
        prev_valid = rx_valid; prev_busy = busy;
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (rx_valid && !prev_valid && v_it < 0) v_it = cur_d;
        if (frame_err) begin
            ferr_cnt++;
            if (ferr_it < 0) ferr_it = cur_d;
        end
        if (busy && bh_it < 0) bh_it = cur_d;
        if (!busy && prev_busy && bl_it < 0) bl_it = cur_d;
        prev_valid = rx_valid;
        prev_busy  = busy;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                              input int ncyc, input int pulse_d, input int ack_d);
        logic v;
        clr_mon();
        for (int d = 0; d < ncyc; d++) begin
            if (d < T)                     v = 1'b0;
            else if (d < 9*T)              v = b[(d - T) / T];
            else if (d < 9*T + stop_len)   v = stop_v;
            else                           v = 1'b1;
            if (d == pulse_d) v = 1'b0;
            rx     = v;
            rx_ack = (d == ack_d);
            cur_d  = d;
            step();
        end
        rx     = 1'b1;
        rx_ack = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_tests++; if ({rx_valid, frame_err, overrun, busy} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {rx_valid, frame_err, overrun, busy}); end
        rst = 1'b0;
        repeat (5) step();
        n_tests++; if ({rx_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {rx_valid, busy}); end
    endtask

    task automatic test_clean();
        send_frame(8'hA5, 1'b1, T, 10*T, -1, -1);
        n_tests++; if (v_it !== 154) begin n_fail++; $display("FAIL clean_valid_cycle: got %0d want 154", v_it); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL clean_data: got %h want a5", rx_data); end
        n_tests++; if (bh_it !== 2) begin n_fail++; $display("FAIL clean_busy_rise: got %0d want 2", bh_it); end
        n_tests++; if (bl_it !== 154) begin n_fail++; $display("FAIL clean_busy_fall: got %0d want 154", bl_it); end
        n_tests++; if (ferr_cnt !== 0 || overrun !== 1'b0) begin n_fail++;
            $display("FAIL clean_errs: ferr=%0d ovr=%b want 0 0", ferr_cnt, overrun); end
        repeat (10) step();
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL clean_hold: got %b want 1", rx_valid); end
        do_ack();
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL clean_ack: got %b want 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 40, 200, -1, -1);
        n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
        n_tests++; if (ferr_it !== 154) begin n_fail++; $display("FAIL ferr_cycle: got %0d want 154", ferr_it); end
        n_tests++; if (v_it !== -1 || rx_valid !== 1'b0) begin n_fail++;
            $display("FAIL ferr_novalid: v_it=%0d valid=%b want -1 0", v_it, rx_valid); end
        n_tests++; if (bl_it !== 186) begin n_fail++; $display("FAIL ferr_busy_fall: got %0d want 186", bl_it); end
    endtask

    task automatic test_glitch();
        clr_mon();
        for (int d = 0; d < 30; d++) begin
            rx = (d < 4) ? 1'b0 : 1'b1;
            cur_d = d;
            step();
        end
        n_tests++; if (bl_it !== 10 || busy !== 1'b0) begin n_fail++;
            $display("FAIL glitch_idle: fall=%0d busy=%b want 10 0", bl_it, busy); end
        n_tests++; if (v_it !== -1 || ferr_cnt !== 0) begin n_fail++;
            $display("FAIL glitch_quiet: v_it=%0d ferr=%0d want -1 0", v_it, ferr_cnt); end
        send_frame(8'h5A, 1'b1, T, 10*T, -1, -1);
        n_tests++; if (rx_data !== 8'h5A || v_it !== 154) begin n_fail++;
            $display("FAIL glitch_next: data=%h cyc=%0d want 5a 154", rx_data, v_it); end
        do_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, T, 10*T, -1, -1);
        n_tests++; if (overrun !== 1'b0 || rx_data !== 8'h11) begin n_fail++;
            $display("FAIL ovr_first: ovr=%b data=%h want 0 11", overrun, rx_data); end
        send_frame(8'h22, 1'b1, T, 10*T, -1, -1);
        n_tests++; if ({overrun, rx_valid} !== 2'b11 || rx_data !== 8'h22) begin n_fail++;
            $display("FAIL ovr_set: ovr/valid=%b data=%h want 11 22", {overrun, rx_valid}, rx_data); end
        do_ack();
        n_tests++; if ({overrun, rx_valid} !== 2'b00) begin n_fail++;
            $display("FAIL ovr_clear: got %b want 00", {overrun, rx_valid}); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h44, 1'b1, T, 10*T, -1, -1);
        send_frame(8'h55, 1'b1, T, 10*T, -1, 154);
        n_tests++; if ({rx_valid, overrun} !== 2'b10) begin n_fail++;
            $display("FAIL same_cycle_flags: valid/ovr=%b want 10", {rx_valid, overrun}); end
        n_tests++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL same_cycle_data: got %h want 55", rx_data); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'hC3, 1'b1, T, 89, -1, -1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rx  = 1'b1;
        rst = 1'b1;
        #2;
        n_tests++; if (rx_data !== 8'h00 || {rx_valid, frame_err, overrun, busy} !== 4'b0000) begin n_fail++;
            $display("FAIL rstmid_outputs: data=%h flags=%b want 00 0000", rx_data, {rx_valid, frame_err, overrun, busy}); end
        @(posedge clk); #1;
        rst = 1'b0;
        clr_mon();
        repeat (20) step();
        send_frame(8'h7E, 1'b1, T, 10*T, -1, -1);
        n_tests++; if (rx_data !== 8'h7E || v_it !== 154) begin n_fail++;
            $display("FAIL rstmid_next: data=%h cyc=%0d want 7e 154", rx_data, v_it); end
        do_ack();
    endtask

    task automatic test_majority();
        logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
        exp = 8'hFF;
`else
        exp = 8'hF7;
`endif
        send_frame(8'hFF, 1'b1, T, 10*T, 8 + 4*T, -1);
        n_tests++; if (rx_data !== exp || rx_valid !== 1'b1) begin n_fail++;
            $display("FAIL majority_data: got %h valid=%b want %h 1", rx_data, rx_valid, exp); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_majority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial-to-parallel UART receive stage: the counterpart that consumes the serial line the UART transmitter drives.
- Frame format is 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- Recovers bytes using a bit-period counter with mid-bit sampling and validates start and stop bits.
- Presents each byte on a valid/ack handshake to the home-controller command decoder, flagging framing errors and overruns.

## Interface
- CLOCK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate
- TICKS_PER_BIT, CLOCK_FREQ/BAUD_RATE, clock cycles per bit; legal range 8..65535
- HALF_TICKS, TICKS_PER_BIT/2, cycles from start-bit detection to start-bit centre

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, asynchronous to clk, idles high
- rx_ack  input  1  consumer accepts current byte; meaningful only while rx_valid=1
- rx_data  output  8  last received byte, held until the next delivery
- rx_valid  output  1  byte available; held until acked or overwritten
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- overrun  output  1  sticky; a byte was delivered while the previous one was un-acked
- busy  output  1  high whenever FSM state is not IDLE

## Operation
- **Synchronizer:** rx passes through a 2-FF synchronizer. Both flops reset to 1. Output is rx_s.
- **Counters:**
  - tick counter: 16 bits, reset 0.
  - bit index: 3 bits, wraps after 7.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:**
  - If rx_s=0, go to START with counter=0.
  - Otherwise stay.
- **START:**
  - Counter increments each cycle.
  - At counter=HALF_TICKS-1, sample.
  - If sample=0, go to DATA with counter=0 and bit index=0.
  - If sample=1, treat as a glitch: return to IDLE, no output activity.
- **DATA:**
  - At counter=TICKS_PER_BIT-1, sample, shift into the data register from the MSB side (right shift), reset counter, increment bit index.
  - After the 8th sample, go to STOP.
- **STOP:** at counter=TICKS_PER_BIT-1, sample.
  - Sample=1: deliver the byte and go to IDLE.
  - Sample=0: pulse frame_err for one cycle, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until rx_s=1, then go to IDLE. This prevents a stuck-low or break line from retriggering.
- **Delivery:** rx_data is loaded and rx_valid is set to 1.
  - If rx_valid was already 1 and rx_ack=0 that cycle, set overrun=1 and overwrite rx_data.
- **Ack:**
  - rx_ack=1 with rx_valid=1 clears rx_valid next cycle and clears overrun.
  - Delivery and ack in the same cycle: the new byte wins, rx_valid stays 1, overrun is not set.
- rx_ack while rx_valid=0 is ignored.

## Timing
- **Reset values:** rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
- **Reset mid-frame:** reset is asynchronous and immediate. The partial byte is discarded. The next start bit after release is received normally.
- **Synchronizer latency:** 2 cycles from rx pin to rx_s.
- Let cycle 0 be the first cycle with rx_s=0 while in IDLE:
  - START is entered at cycle 1.
  - Start sample at cycle HALF_TICKS.
  - Data bit k sampled at cycle HALF_TICKS+(k+1)·TICKS_PER_BIT.
  - Stop sample at cycle HALF_TICKS+9·TICKS_PER_BIT.
  - rx_valid or frame_err is asserted the following cycle.
- **busy:**
  - Rises at cycle 1.
  - Falls the cycle after the stop sample (valid frame), or the cycle after rx_s returns high (WAIT_HIGH).
- **Back-to-back frames:** a new start bit is accepted immediately after returning to IDLE. Up to ~HALF_TICKS of transmitter-side bit-period mismatch per frame is tolerated.

## Configuration
- **Macro:** UART_RX_MAJORITY_EN.
- **Defined:**
  - Each sample point uses a 2-of-3 majority vote of rx_s taken at counter values N-3, N-2 and N-1, where N is HALF_TICKS (start) or TICKS_PER_BIT (data/stop).
  - The decision is made at N-1, so latency is unchanged.
  - Requires TICKS_PER_BIT≥8.
- **Undefined:** a single sample of rx_s at counter N-1; no vote registers are synthesized.

## Structure
- **Shared package uart_pkg:**
  - Default CLOCK_FREQ and BAUD_RATE constants.
  - The TICKS_PER_BIT derivation function.
  - The rx FSM state typedef (IDLE/START/DATA/STOP/WAIT_HIGH).
  - The frame length constant DATA_BITS=8.
- **Sub-module uart_rx_sync:** 2-FF synchronizer with reset-to-1, instantiated once.

## Test plan
All scenarios use CLOCK_FREQ=160000, BAUD_RATE=10000 (TICKS_PER_BIT=16, HALF_TICKS=8).

- **Clean byte:** ideal frame carrying 0xA5 → rx_valid=1 with rx_data=0xA5 at the cycle given in Timing; rx_valid holds until rx_ack, then clears next cycle; frame_err and overrun stay 0.
- **Framing error:** frame 0x3C with stop bit driven 0 for 40 cycles → one-cycle frame_err pulse, rx_valid stays 0, busy stays high until rx returns to 1, then busy=0.
- **Start glitch:** rx low for 4 cycles, then high → FSM returns to IDLE, no rx_valid, no frame_err; a following 0x5A frame is received correctly.
- **Overrun:** frames 0x11 then 0x22 back-to-back with no ack → overrun=1, rx_data=0x22, rx_valid=1; rx_ack clears both.
- **Reset mid-frame:** rst pulsed during data bit 4 of 0xC3 → all outputs at reset values; the next frame 0x7E is delivered as 0x7E.
- **Majority vote:** frame 0xFF with a 1-cycle low pulse at counter=TICKS_PER_BIT-1 of bit 3 → with UART_RX_MAJORITY_EN rx_data=0xFF; without it rx_data=0xF7.
